// File: rtl/lane_tx_gearbox_if.sv
// Block/word handshake between the lane scheduler, the TX gearbox and the serializer.
interface lane_tx_gearbox_if;
   localparam int unsigned BLOCK_W = 66;
   localparam int unsigned OUT_W   = 32;

   logic               in_valid;
   logic [BLOCK_W-1:0] in_block;
   logic               in_ready;
   logic               out_valid;
   logic [OUT_W-1:0]   out_data;
   logic               underflow_err;

   // Upstream driver / downstream consumer view
   modport master (
      output in_valid, in_block,
      input  in_ready, out_valid, out_data, underflow_err
   );

   // Gearbox view
   modport slave (
      input  in_valid, in_block,
      output in_ready, out_valid, out_data, underflow_err
   );
endinterface

// File: rtl/lane_tx_gearbox.sv
// Per-lane TX gearbox: optional self-sync payload scrambling (x^58+x^39+1) and
// 66b -> 32b packing on a fixed 66-cycle schedule (32 blocks in, 66 words out).
module lane_tx_gearbox #(
   parameter int unsigned BLOCK_W     = 66,
   parameter int unsigned OUT_W       = 32,
   parameter bit          SCRAMBLE_EN = 1'b1,
   parameter logic [57:0] SCR_SEED    = 58'h3FF_FFFF_FFFF_FFFF
) (
   input logic             clk,
   input logic             rst_n,
   input logic             lane_enable,
   lane_tx_gearbox_if.slave bus
);

   localparam int unsigned HDR_W     = 2;
   localparam int unsigned PAY_W     = BLOCK_W - HDR_W;
   localparam int unsigned SCR_W     = 58;
   localparam int unsigned TAP_A     = 38;
   localparam int unsigned TAP_B     = 57;
   localparam int unsigned BUF_W     = 128;
   localparam int unsigned FILL_W    = 8;
   localparam int unsigned PH_W      = 7;
   localparam int unsigned PH_LAST   = 65;
   localparam int unsigned PH_ACC_END = 64;
   localparam logic [BLOCK_W-1:0] IDLE_BLK = {PAY_W'(64'h1E), 2'b10};

   logic               run_q, run_nxt;
   logic [PH_W-1:0]    phase_q, phase_nxt;
   logic [FILL_W-1:0]  fill_q, fill_nxt, fill_pre;
   logic [BUF_W-1:0]   buf_q, buf_nxt, buf_ext;
   logic [SCR_W-1:0]   scr_q, scr_nxt, scr_st;
   logic               in_ready_q, in_ready_nxt;
   logic               out_valid_q, out_valid_nxt;
   logic [OUT_W-1:0]   out_data_q, out_data_nxt;
   logic               uf_q, uf_nxt;
   logic [BLOCK_W-1:0] blk, blk_tx;
   logic [PAY_W-1:0]   scr_pay;
   logic               sb;
   logic               accept;

   // Block selection, unrolled scrambler, packing and schedule next-state
   always_comb begin
      run_nxt       = lane_enable;
      phase_nxt     = '0;
      fill_nxt      = '0;
      buf_nxt       = '0;
      out_valid_nxt = 1'b0;
      out_data_nxt  = '0;
      sb            = 1'b0;
      scr_pay       = '0;

      accept = in_ready_q;
      blk    = bus.in_valid ? bus.in_block : IDLE_BLK;
      uf_nxt = accept & ~bus.in_valid;

      scr_st = scr_q;
      for (int i = 0; i < int'(PAY_W); i++) begin
         sb         = blk[HDR_W + i] ^ scr_st[TAP_A] ^ scr_st[TAP_B];
         scr_pay[i] = sb;
         scr_st     = {scr_st[SCR_W-2:0], sb};
      end
      blk_tx  = SCRAMBLE_EN ? {scr_pay, blk[HDR_W-1:0]} : blk;
      scr_nxt = accept ? scr_st : scr_q;

      fill_pre = fill_q + (accept ? FILL_W'(BLOCK_W) : FILL_W'(0));
      buf_ext  = accept ? (buf_q | (BUF_W'(blk_tx) << fill_q)) : buf_q;

      // Dropping the lane discards everything already buffered
      if (run_q && lane_enable) begin
         phase_nxt     = (phase_q == PH_W'(PH_LAST)) ? '0 : PH_W'(phase_q + PH_W'(1));
         fill_nxt      = fill_pre - FILL_W'(OUT_W);
         buf_nxt       = buf_ext >> OUT_W;
         out_data_nxt  = buf_ext[OUT_W-1:0];
         out_valid_nxt = 1'b1;
      end

      in_ready_nxt = run_nxt & ~phase_nxt[0] & (phase_nxt < PH_W'(PH_ACC_END));
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q       <= 1'b0;
         phase_q     <= '0;
         fill_q      <= '0;
         buf_q       <= '0;
         scr_q       <= SCR_SEED;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         uf_q        <= 1'b0;
      end else begin
         run_q       <= run_nxt;
         phase_q     <= phase_nxt;
         fill_q      <= fill_nxt;
         buf_q       <= buf_nxt;
         scr_q       <= scr_nxt;
         in_ready_q  <= in_ready_nxt;
         out_valid_q <= out_valid_nxt;
         out_data_q  <= out_data_nxt;
         uf_q        <= uf_nxt;
      end
   end

   // A full word must always be available before each shift
   always_ff @(posedge clk) begin
      if (rst_n && run_q && lane_enable) begin
         a_fill_ok: assert (fill_pre >= FILL_W'(OUT_W));
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_data      = out_data_q;
   assign bus.underflow_err = uf_q;

endmodule
